// File: rtl/tl45_pkg.sv
// Shared definitions for the tl45 operand-fetch stage: opcodes, sizes and FSM states.
package tl45_pkg;

    localparam int REG_W = 4;

    localparam logic [4:0] OP_NOP = 5'h00;
    localparam logic [4:0] OP_ADD = 5'h01;
    localparam logic [4:0] OP_SUB = 5'h02;
    localparam logic [4:0] OP_BR  = 5'h0C;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/tl45_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous write port.
// Register 0 always reads as zero and is never written.
module tl45_regfile
    import tl45_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [REG_W-1:0]  i_rd_addr_a,
    input  logic [REG_W-1:0]  i_rd_addr_b,
    output logic [DATA_W-1:0] o_rd_data_a,
    output logic [DATA_W-1:0] o_rd_data_b,
    input  logic              i_wr_en,
    input  logic [REG_W-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    // Next register contents: apply the single write port, keep r0 pinned at zero.
    always_comb begin
        regs_d = regs_q;
        if (i_wr_en && (i_wr_addr != {REG_W{1'b0}})) begin
            regs_d[i_wr_addr] = i_wr_data;
        end else begin
            regs_d = regs_q;
        end
        regs_d[0] = {DATA_W{1'b0}};
    end

    // Register storage with synchronous active-low clear.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign o_rd_data_a = (i_rd_addr_a == {REG_W{1'b0}}) ? {DATA_W{1'b0}} : regs_q[i_rd_addr_a];
    assign o_rd_data_b = (i_rd_addr_b == {REG_W{1'b0}}) ? {DATA_W{1'b0}} : regs_q[i_rd_addr_b];

endmodule

// File: rtl/tl45_opfetch.sv
// Operand-fetch stage: reads the register file, resolves forwarding and loads the
// registered operand buffer feeding execute, inserting bubbles on load-use hazards.
module tl45_opfetch
    import tl45_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_pipe_stall,
    input  logic              i_pipe_flush,
    output logic              o_pipe_stall,
    output logic              o_pipe_flush,
    input  logic [4:0]        i_opcode,
    input  logic [REG_W-1:0]  i_dr,
    input  logic [REG_W-1:0]  i_sr1,
    input  logic [REG_W-1:0]  i_sr2,
    input  logic              i_use_imm,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [3:0]        i_jmp_cond,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [REG_W-1:0]  i_of_reg,
    input  logic [DATA_W-1:0] i_of_val,
    input  logic [REG_W-1:0]  i_wb_reg,
    input  logic [DATA_W-1:0] i_wb_val,
    input  logic [REG_W-1:0]  i_ld_busy_reg,
    output logic [4:0]        o_opcode,
    output logic [REG_W-1:0]  o_dr,
    output logic [3:0]        o_jmp_cond,
    output logic [DATA_W-1:0] o_sr1_val,
    output logic [DATA_W-1:0] o_sr2_val,
    output logic [DATA_W-1:0] o_target_offset,
    output logic [DATA_W-1:0] o_pc
);

    logic [DATA_W-1:0] rf_a_s;
    logic [DATA_W-1:0] rf_b_s;
    logic [DATA_W-1:0] sr1_res_s;
    logic [DATA_W-1:0] sr2_res_s;
    logic              hazard_s;

    state_e            state_q, state_d;
    logic [4:0]        opcode_q, opcode_d;
    logic [REG_W-1:0]  dr_q, dr_d;
    logic [3:0]        jmp_cond_q, jmp_cond_d;
    logic [DATA_W-1:0] sr1_val_q, sr1_val_d;
    logic [DATA_W-1:0] sr2_val_q, sr2_val_d;
    logic [DATA_W-1:0] target_q, target_d;
    logic [DATA_W-1:0] pc_q, pc_d;

    // Execute-stage forward wins over the writeback port, which wins over stored state.
    function automatic logic [DATA_W-1:0] resolve(
        input logic [REG_W-1:0]  idx,
        input logic [REG_W-1:0]  of_reg,
        input logic [DATA_W-1:0] of_val,
        input logic [REG_W-1:0]  wb_reg,
        input logic [DATA_W-1:0] wb_val,
        input logic [DATA_W-1:0] rf_val
    );
        logic [DATA_W-1:0] res;
        if (idx == {REG_W{1'b0}}) begin
            res = {DATA_W{1'b0}};
        end else if (idx == of_reg) begin
            res = of_val;
        end else if (idx == wb_reg) begin
            res = wb_val;
        end else begin
            res = rf_val;
        end
        return res;
    endfunction

    tl45_regfile #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rd_addr_a (i_sr1),
        .i_rd_addr_b (i_sr2),
        .o_rd_data_a (rf_a_s),
        .o_rd_data_b (rf_b_s),
        .i_wr_en     (i_wb_reg != {REG_W{1'b0}}),
        .i_wr_addr   (i_wb_reg),
        .i_wr_data   (i_wb_val)
    );

    assign hazard_s = (i_ld_busy_reg != {REG_W{1'b0}}) &&
                      ((i_ld_busy_reg == i_sr1) || (!i_use_imm && (i_ld_busy_reg == i_sr2)));

    assign sr1_res_s = resolve(i_sr1, i_of_reg, i_of_val, i_wb_reg, i_wb_val, rf_a_s);
    assign sr2_res_s = i_use_imm ? i_imm
                                 : resolve(i_sr2, i_of_reg, i_of_val, i_wb_reg, i_wb_val, rf_b_s);

    assign o_pipe_stall = i_pipe_stall | hazard_s;
    assign o_pipe_flush = i_pipe_flush;

    // Next buffer contents and FSM state: flush > stall > hazard bubble > capture.
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        dr_d       = dr_q;
        jmp_cond_d = jmp_cond_q;
        sr1_val_d  = sr1_val_q;
        sr2_val_d  = sr2_val_q;
        target_d   = target_q;
        pc_d       = pc_q;

        case (state_q)
            ST_RUN:  state_d = hazard_s ? ST_WAIT : ST_RUN;
            ST_WAIT: state_d = hazard_s ? ST_WAIT : ST_RUN;
            default: state_d = ST_RUN;
        endcase

        if (i_pipe_flush) begin
            state_d    = ST_RUN;
            opcode_d   = OP_NOP;
            dr_d       = {REG_W{1'b0}};
            jmp_cond_d = 4'h0;
            sr1_val_d  = {DATA_W{1'b0}};
            sr2_val_d  = {DATA_W{1'b0}};
            target_d   = {DATA_W{1'b0}};
            pc_d       = {DATA_W{1'b0}};
        end else if (i_pipe_stall) begin
            state_d = state_q;
        end else if (hazard_s) begin
            opcode_d   = OP_NOP;
            dr_d       = {REG_W{1'b0}};
            jmp_cond_d = 4'h0;
            sr1_val_d  = {DATA_W{1'b0}};
            sr2_val_d  = {DATA_W{1'b0}};
            target_d   = {DATA_W{1'b0}};
            pc_d       = {DATA_W{1'b0}};
        end else begin
            opcode_d   = i_opcode;
            dr_d       = i_dr;
            jmp_cond_d = i_jmp_cond;
            pc_d       = i_pc;
            sr1_val_d  = sr1_res_s;
            if (i_opcode == OP_BR) begin
                sr2_val_d = {DATA_W{1'b0}};
                target_d  = i_imm;
            end else begin
                sr2_val_d = sr2_res_s;
                target_d  = {DATA_W{1'b0}};
            end
        end
    end

    // Operand buffer and FSM state registers.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= ST_RUN;
            opcode_q   <= OP_NOP;
            dr_q       <= {REG_W{1'b0}};
            jmp_cond_q <= 4'h0;
            sr1_val_q  <= {DATA_W{1'b0}};
            sr2_val_q  <= {DATA_W{1'b0}};
            target_q   <= {DATA_W{1'b0}};
            pc_q       <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            dr_q       <= dr_d;
            jmp_cond_q <= jmp_cond_d;
            sr1_val_q  <= sr1_val_d;
            sr2_val_q  <= sr2_val_d;
            target_q   <= target_d;
            pc_q       <= pc_d;
        end
    end

    assign o_opcode        = opcode_q;
    assign o_dr            = dr_q;
    assign o_jmp_cond      = jmp_cond_q;
    assign o_sr1_val       = sr1_val_q;
    assign o_sr2_val       = sr2_val_q;
    assign o_target_offset = target_q;
    assign o_pc            = pc_q;

endmodule

// File: tb/tb_tl45_opfetch.sv
// Directed self-checking bench for tl45_opfetch with hand-computed expected values.
module tb_tl45_opfetch;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_pipe_stall, i_pipe_flush;
    logic        o_pipe_stall, o_pipe_flush;
    logic [4:0]  i_opcode;
    logic [3:0]  i_dr, i_sr1, i_sr2;
    logic        i_use_imm;
    logic [31:0] i_imm;
    logic [3:0]  i_jmp_cond;
    logic [31:0] i_pc;
    logic [3:0]  i_of_reg;
    logic [31:0] i_of_val;
    logic [3:0]  i_wb_reg;
    logic [31:0] i_wb_val;
    logic [3:0]  i_ld_busy_reg;
    logic [4:0]  o_opcode;
    logic [3:0]  o_dr, o_jmp_cond;
    logic [31:0] o_sr1_val, o_sr2_val, o_target_offset, o_pc;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    tl45_opfetch dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_pipe_stall    (i_pipe_stall),
        .i_pipe_flush    (i_pipe_flush),
        .o_pipe_stall    (o_pipe_stall),
        .o_pipe_flush    (o_pipe_flush),
        .i_opcode        (i_opcode),
        .i_dr            (i_dr),
        .i_sr1           (i_sr1),
        .i_sr2           (i_sr2),
        .i_use_imm       (i_use_imm),
        .i_imm           (i_imm),
        .i_jmp_cond      (i_jmp_cond),
        .i_pc            (i_pc),
        .i_of_reg        (i_of_reg),
        .i_of_val        (i_of_val),
        .i_wb_reg        (i_wb_reg),
        .i_wb_val        (i_wb_val),
        .i_ld_busy_reg   (i_ld_busy_reg),
        .o_opcode        (o_opcode),
        .o_dr            (o_dr),
        .o_jmp_cond      (o_jmp_cond),
        .o_sr1_val       (o_sr1_val),
        .o_sr2_val       (o_sr2_val),
        .o_target_offset (o_target_offset),
        .o_pc            (o_pc)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_pipe_stall  = 1'b0;
        i_pipe_flush  = 1'b0;
        i_opcode      = 5'h00;
        i_dr          = 4'h0;
        i_sr1         = 4'h0;
        i_sr2         = 4'h0;
        i_use_imm     = 1'b0;
        i_imm         = 32'h0;
        i_jmp_cond    = 4'h0;
        i_pc          = 32'h0;
        i_of_reg      = 4'h0;
        i_of_val      = 32'h0;
        i_wb_reg      = 4'h0;
        i_wb_val      = 32'h0;
        i_ld_busy_reg = 4'h0;
    endtask

    task automatic write_reg(input logic [3:0] r, input logic [31:0] v);
        clear_inputs();
        i_wb_reg = r;
        i_wb_val = v;
        step();
        i_wb_reg = 4'h0;
        i_wb_val = 32'h0;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_opcode"}, {27'h0, o_opcode}, 32'h0);
        check_val({tag, "_dr"}, {28'h0, o_dr}, 32'h0);
        check_val({tag, "_cond"}, {28'h0, o_jmp_cond}, 32'h0);
        check_val({tag, "_sr1"}, o_sr1_val, 32'h0);
        check_val({tag, "_sr2"}, o_sr2_val, 32'h0);
        check_val({tag, "_tgt"}, o_target_offset, 32'h0);
        check_val({tag, "_pc"}, o_pc, 32'h0);
    endtask

    initial begin
        clear_inputs();
        i_reset = 1'b0;
        step();
        i_reset = 1'b1;
        write_reg(4'd5, 32'h0000_00AA);

        // Reset held two cycles while a live ADD is presented
        clear_inputs();
        i_reset = 1'b0;
        i_opcode = 5'h01; i_dr = 4'd3; i_sr1 = 4'd5; i_sr2 = 4'd5;
        i_pc = 32'h0000_0040; i_jmp_cond = 4'h2;
        step();
        step();
        check_all_zero("reset");
        i_reset = 1'b1;
        for (int r = 1; r < 16; r++) begin
            clear_inputs();
            i_opcode = 5'h01;
            i_sr1 = 4'(r);
            i_sr2 = 4'(r);
            step();
            check_val($sformatf("rst_rd_r%0d", r), o_sr1_val | o_sr2_val, 32'h0);
        end

        // Forwarding priority on r3
        write_reg(4'd3, 32'd5);
        clear_inputs();
        i_opcode = 5'h01; i_sr1 = 4'd3; i_dr = 4'd1;
        step();
        check_val("fwd_rf", o_sr1_val, 32'd5);
        i_wb_reg = 4'd3; i_wb_val = 32'd7;
        i_of_reg = 4'd3; i_of_val = 32'd9;
        step();
        check_val("fwd_of", o_sr1_val, 32'd9);
        i_of_reg = 4'd0;
        step();
        check_val("fwd_wb", o_sr1_val, 32'd7);
        i_wb_reg = 4'd0;
        step();
        check_val("fwd_after_wr", o_sr1_val, 32'd7);
        check_val("fwd_opcode", {27'h0, o_opcode}, 32'h1);
        check_val("fwd_dr", {28'h0, o_dr}, 32'h1);

        // Immediate operand
        clear_inputs();
        i_opcode = 5'h02; i_dr = 4'd2; i_use_imm = 1'b1; i_imm = 32'h0000_1234;
        i_sr2 = 4'd3; i_pc = 32'h0000_0010;
        step();
        check_val("imm_sr2", o_sr2_val, 32'h0000_1234);
        check_val("imm_tgt", o_target_offset, 32'h0);
        check_val("imm_pc", o_pc, 32'h0000_0010);
        check_val("imm_opcode", {27'h0, o_opcode}, 32'h2);

        // Load-use hazard on sr2
        write_reg(4'd4, 32'h0000_0044);
        clear_inputs();
        i_opcode = 5'h01; i_dr = 4'd5; i_sr2 = 4'd4; i_ld_busy_reg = 4'd4;
        #1;
        check_val("lu_stall", {31'h0, o_pipe_stall}, 32'h1);
        step();
        check_all_zero("lu_bubble");
        step();
        check_val("lu_wait_opcode", {27'h0, o_opcode}, 32'h0);
        check_val("lu_wait_stall", {31'h0, o_pipe_stall}, 32'h1);
        i_ld_busy_reg = 4'd0;
        #1;
        check_val("lu_release_stall", {31'h0, o_pipe_stall}, 32'h0);
        step();
        check_val("lu_issue_opcode", {27'h0, o_opcode}, 32'h1);
        check_val("lu_issue_sr2", o_sr2_val, 32'h0000_0044);
        check_val("lu_issue_dr", {28'h0, o_dr}, 32'h5);

        // Busy register matches sr2 but immediate is used: no hazard
        i_ld_busy_reg = 4'd4; i_use_imm = 1'b1; i_imm = 32'd8;
        #1;
        check_val("imm_nohaz_stall", {31'h0, o_pipe_stall}, 32'h0);
        step();
        check_val("imm_nohaz_sr2", o_sr2_val, 32'd8);

        // Hazard via sr1, then flush while waiting
        i_use_imm = 1'b0; i_sr2 = 4'd0; i_sr1 = 4'd4;
        #1;
        check_val("sr1_haz_stall", {31'h0, o_pipe_stall}, 32'h1);
        step();
        check_val("sr1_haz_bubble", {27'h0, o_opcode}, 32'h0);
        i_pipe_flush = 1'b1;
        #1;
        check_val("flush_out", {31'h0, o_pipe_flush}, 32'h1);
        step();
        check_all_zero("flush_wait");
        clear_inputs();
        i_opcode = 5'h01; i_sr1 = 4'd4; i_dr = 4'd9; i_pc = 32'h0000_0020;
        step();
        check_val("post_flush_opcode", {27'h0, o_opcode}, 32'h1);
        check_val("post_flush_sr1", o_sr1_val, 32'h0000_0044);

        // Stall window: outputs hold, writeback still lands
        i_pipe_stall = 1'b1;
        i_opcode = 5'h02; i_sr1 = 4'd3; i_pc = 32'h0000_0099;
        i_wb_reg = 4'd6; i_wb_val = 32'h0000_0066;
        step();
        check_val("stall1_opcode", {27'h0, o_opcode}, 32'h1);
        check_val("stall1_sr1", o_sr1_val, 32'h0000_0044);
        check_val("stall1_out", {31'h0, o_pipe_stall}, 32'h1);
        i_wb_reg = 4'd0; i_opcode = 5'h0C; i_imm = 32'h0000_0055; i_dr = 4'd2;
        step();
        check_val("stall2_pc", o_pc, 32'h0000_0020);
        check_val("stall2_tgt", o_target_offset, 32'h0);
        i_ld_busy_reg = 4'd3;
        step();
        check_val("stall_haz_opcode", {27'h0, o_opcode}, 32'h1);
        check_val("stall_haz_dr", {28'h0, o_dr}, 32'h9);
        clear_inputs();
        i_opcode = 5'h01; i_sr1 = 4'd6;
        step();
        check_val("stall_wb_visible", o_sr1_val, 32'h0000_0066);

        // Flush clears a populated buffer
        i_pipe_flush = 1'b1;
        step();
        check_all_zero("flush_full");

        // Branch
        write_reg(4'd2, 32'h0000_0100);
        clear_inputs();
        i_opcode = 5'h0C; i_sr1 = 4'd2; i_sr2 = 4'd4; i_imm = 32'h0000_0020;
        i_dr = 4'd7; i_jmp_cond = 4'h3; i_pc = 32'h0000_0400;
        step();
        check_val("br_sr1", o_sr1_val, 32'h0000_0100);
        check_val("br_tgt", o_target_offset, 32'h0000_0020);
        check_val("br_sr2", o_sr2_val, 32'h0);
        check_val("br_dr", {28'h0, o_dr}, 32'h7);
        check_val("br_cond", {28'h0, o_jmp_cond}, 32'h3);
        check_val("br_pc", o_pc, 32'h0000_0400);
        check_val("br_opcode", {27'h0, o_opcode}, 32'h0000_000C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
